mcs_fpro_bridge_seq: RTL

- Registered bridge between the MicroBlaze MCS I/O bus and the FPro MMIO bus.
- Drives the MMIO subsystem's mmio_cs/mmio_wr/mmio_rd/mmio_addr/mmio_wr_data and samples its mmio_rd_data.
- Sits directly upstream of the MMIO slot controller.
- Adds address-range checking, one-access-at-a-time sequencing and a single-cycle io_ready response.

---
 rtl/mcs_fpro_bridge_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mcs_fpro_bridge_seq.sv
// Registered MicroBlaze MCS I/O bus to FPro MMIO bridge: range check, one access at a time, 1-cycle io_ready.
// Optional read-modify-write for partial-byte writes when BRG_BYTE_MERGE_EN is defined.
module mcs_fpro_bridge_seq #(
    parameter logic [31:0] BRG_BASE   = 32'hc000_0000,
    parameter logic [31:0] RD_ERR_VAL = 32'hffff_ffff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_addr_strobe,
    input  logic        io_read_strobe,
    input  logic        io_write_strobe,
    input  logic [3:0]  io_byte_enable,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        io_ready,
    output logic        fp_mmio_cs,
    output logic        fp_wr,
    output logic        fp_rd,
    output logic [20:0] fp_addr,
    output logic [31:0] fp_wr_data,
    input  logic [31:0] fp_rd_data,
    output logic        bus_err
);

    localparam int unsigned AW = 21;
    localparam int unsigned DW = 32;

`ifdef BRG_BYTE_MERGE_EN
    typedef enum logic [1:0] {IDLE, BUS, RESP, RMW_RD} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
`endif

    state_t          state_q, state_d;
    logic            wr_q, wr_d;
    logic            io_ready_q, io_ready_d;
    logic [DW-1:0]   io_read_data_q, io_read_data_d;
    logic            fp_cs_q, fp_cs_d;
    logic            fp_wr_q, fp_wr_d;
    logic            fp_rd_q, fp_rd_d;
    logic [AW-1:0]   fp_addr_q, fp_addr_d;
    logic [DW-1:0]   fp_wr_data_q, fp_wr_data_d;
    logic            bus_err_q, bus_err_d;
    logic            in_range;
    logic            capture;
`ifdef BRG_BYTE_MERGE_EN
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [DW-1:0]   merged;
`endif

    assign in_range = (io_address[31:24] == BRG_BASE[31:24]) && !io_address[23];
    assign capture  = (state_q == IDLE) && io_addr_strobe;

    // Read qualifier is implied (no write strobe means read); low address bits select nothing.
    logic unused_ok;
`ifdef BRG_BYTE_MERGE_EN
    assign unused_ok = ^{io_read_strobe, io_address[1:0]};
`else
    assign unused_ok = ^{io_read_strobe, io_address[1:0], io_byte_enable};
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            wr_q           <= 1'b0;
            io_ready_q     <= 1'b0;
            io_read_data_q <= '0;
            fp_cs_q        <= 1'b0;
            fp_wr_q        <= 1'b0;
            fp_rd_q        <= 1'b0;
            fp_addr_q      <= '0;
            fp_wr_data_q   <= '0;
            bus_err_q      <= 1'b0;
`ifdef BRG_BYTE_MERGE_EN
            wdata_q        <= '0;
            be_q           <= '0;
`endif
        end else begin
            state_q        <= state_d;
            wr_q           <= wr_d;
            io_ready_q     <= io_ready_d;
            io_read_data_q <= io_read_data_d;
            fp_cs_q        <= fp_cs_d;
            fp_wr_q        <= fp_wr_d;
            fp_rd_q        <= fp_rd_d;
            fp_addr_q      <= fp_addr_d;
            fp_wr_data_q   <= fp_wr_data_d;
            bus_err_q      <= bus_err_d;
`ifdef BRG_BYTE_MERGE_EN
            wdata_q        <= wdata_d;
            be_q           <= be_d;
`endif
        end
    end

    // Next state and captured access type
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
`ifdef BRG_BYTE_MERGE_EN
        wdata_d = wdata_q;
        be_d    = be_q;
`endif
        case (state_q)
            IDLE: begin
                if (io_addr_strobe) begin
                    wr_d = io_write_strobe;
`ifdef BRG_BYTE_MERGE_EN
                    wdata_d = io_write_data;
                    be_d    = io_byte_enable;
                    if (!in_range)
                        state_d = RESP;
                    else if (io_write_strobe && (io_byte_enable == 4'h0))
                        state_d = RESP;
                    else if (io_write_strobe && (io_byte_enable != 4'hf))
                        state_d = RMW_RD;
                    else
                        state_d = BUS;
`else
                    state_d = in_range ? BUS : RESP;
`endif
                end
            end
            BUS:     state_d = RESP;
            RESP:    state_d = IDLE;
`ifdef BRG_BYTE_MERGE_EN
            RMW_RD:  state_d = BUS;
`endif
            default: state_d = IDLE;
        endcase
    end

`ifdef BRG_BYTE_MERGE_EN
    // Byte-lane merge of new write data over the word read during RMW_RD
    always_comb begin
        merged = fp_rd_data;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i])
                merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end
`endif

    // Registered outputs, aligned with the state being entered
    always_comb begin
        fp_cs_d        = 1'b0;
        fp_wr_d        = 1'b0;
        fp_rd_d        = 1'b0;
        io_ready_d     = 1'b0;
        io_read_data_d = '0;
        fp_addr_d      = fp_addr_q;
        fp_wr_data_d   = fp_wr_data_q;
        bus_err_d      = bus_err_q;

        if (capture && in_range) begin
            fp_addr_d = io_address[22:2];
            if (io_write_strobe)
                fp_wr_data_d = io_write_data;
        end
        if ((capture && !in_range) || (io_addr_strobe && (state_q != IDLE)))
            bus_err_d = 1'b1;

        case (state_d)
            BUS: begin
                fp_cs_d = 1'b1;
                fp_wr_d = wr_d;
                fp_rd_d = !wr_d;
`ifdef BRG_BYTE_MERGE_EN
                if (state_q == RMW_RD)
                    fp_wr_data_d = merged;
`endif
            end
`ifdef BRG_BYTE_MERGE_EN
            RMW_RD: begin
                fp_cs_d = 1'b1;
                fp_rd_d = 1'b1;
            end
`endif
            RESP: begin
                io_ready_d = 1'b1;
                if (state_q == BUS)
                    io_read_data_d = wr_q ? DW'(0) : fp_rd_data;
                else if (!io_write_strobe && !in_range)
                    io_read_data_d = RD_ERR_VAL;
            end
            default: ;
        endcase
    end

    assign io_ready     = io_ready_q;
    assign io_read_data = io_read_data_q;
    assign fp_mmio_cs   = fp_cs_q;
    assign fp_wr        = fp_wr_q;
    assign fp_rd        = fp_rd_q;
    assign fp_addr      = fp_addr_q;
    assign fp_wr_data   = fp_wr_data_q;
    assign bus_err      = bus_err_q;

endmodule
